// File: rtl/rf_pkg.sv
//==============================================================================
// Module      : rf_pkg
// Description : Shared constants, types and helpers for the scoreboarded
//               register file (reset image, default widths, read-source enum).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package rf_pkg;

    localparam int RF_DW_DEFAULT = 8;
    localparam int RF_AW_DEFAULT = 3;
    localparam int RF_INIT_N     = 8;

    // Reset image for the first eight registers, index 7 at the MSB end.
    // R5 = 0x01 and R6 = 0x07; every other register resets to zero.
    localparam logic [RF_INIT_N-1:0][7:0] RF_INIT = {
        8'h00, 8'h07, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    // Where a read port takes its data from in a given cycle.
    typedef enum logic [1:0] {
        RD_SRC_STORE = 2'd0,
        RD_SRC_WR    = 2'd1,
        RD_SRC_COUT  = 2'd2,
        RD_SRC_ZERO  = 2'd3
    } rd_src_e;

    // Reset value of register idx; registers beyond the table reset to zero.
    function automatic logic [7:0] rf_init_value(input int idx);
        logic [7:0] val;
        val = 8'h00;
        if (idx >= 0 && idx < RF_INIT_N) begin
            val = RF_INIT[idx];
        end
        return val;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rf_scoreboard.sv
//==============================================================================
// Module      : rf_scoreboard
// Description : Busy-bit scoreboard for the register file. A producer issue
//               (alloc) marks a register busy; the general write or the COUT
//               write retires it. Flags re-allocation of a busy register.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rf_scoreboard #(
    parameter int AW       = 3,
    parameter int COUT_IDX = 7,
    parameter int R0_ZERO  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic              cout_we,
    input  logic              alloc_en,
    input  logic [AW-1:0]     alloc_addr,
    output logic [2**AW-1:0]  busy_vec,
    output logic              alloc_err
);

    localparam int            NREG   = 2**AW;
    localparam logic [AW-1:0] COUT_A = AW'(COUT_IDX);

    logic [NREG-1:0] busy_nxt;
    logic            alloc_ok;

    // Register 0 never tracks a producer when it is hardwired to zero.
    assign alloc_ok = alloc_en && !((R0_ZERO != 0) && (alloc_addr == '0));

    // Next busy vector: retire on writes first, so a same-cycle alloc wins.
    always_comb begin
        busy_nxt = busy_vec;
        if (wr_en) begin
            busy_nxt[wr_addr] = 1'b0;
        end
        if (cout_we) begin
            busy_nxt[COUT_A] = 1'b0;
        end
        if (alloc_ok) begin
            busy_nxt[alloc_addr] = 1'b1;
        end
    end

    // Busy state and the one-cycle re-allocation error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_vec  <= '0;
            alloc_err <= 1'b0;
        end else begin
            busy_vec  <= busy_nxt;
            alloc_err <= alloc_ok && busy_vec[alloc_addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/reg_file_sb.sv
//==============================================================================
// Module      : reg_file_sb
// Description : Multi-read-port register file with a dedicated carry-out
//               (COUT) write port and a producer busy scoreboard.
//               Optional macro RF_BYPASS_EN forwards same-cycle write data
//               to the read ports (COUT data has priority over wr_data).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module reg_file_sb
    import rf_pkg::*;
#(
    parameter int DW       = RF_DW_DEFAULT,
    parameter int AW       = RF_AW_DEFAULT,
    parameter int NRD      = 2,
    parameter int COUT_IDX = 2**AW - 1,
    parameter int R0_ZERO  = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NRD-1:0][AW-1:0]   rd_addr,
    output logic [NRD-1:0][DW-1:0]   rd_data,
    output logic [NRD-1:0]           rd_busy,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DW-1:0]            wr_data,
    input  logic                     cout_we,
    input  logic [DW-1:0]            cout_data,
    input  logic                     alloc_en,
    input  logic [AW-1:0]            alloc_addr,
    output logic [2**AW-1:0]         busy_vec,
    output logic                     alloc_err
);

    localparam int            NREG   = 2**AW;
    localparam logic [AW-1:0] COUT_A = AW'(COUT_IDX);

    // Elaboration-time parameter sanity.
    if (COUT_IDX < 0 || COUT_IDX >= NREG) begin : g_bad_cout_idx
        $error("reg_file_sb: COUT_IDX out of range");
    end
    if (NRD < 1 || NRD > 4) begin : g_bad_nrd
        $error("reg_file_sb: NRD must be 1..4");
    end

    logic [DW-1:0] mem [NREG];
    logic          wr_ok;
    logic          cout_ok;
    rd_src_e       rd_src [NRD];

    // A hardwired-zero R0 silently swallows any write aimed at it.
    assign wr_ok   = wr_en   && !((R0_ZERO != 0) && (wr_addr == '0));
    assign cout_ok = cout_we && !((R0_ZERO != 0) && (COUT_A == '0));

    // Storage: async reset to the package image; COUT write lands last so it wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= DW'(rf_init_value(i));
            end
        end else begin
            if (wr_ok) begin
                mem[wr_addr] <= wr_data;
            end
            if (cout_ok) begin
                mem[COUT_A] <= cout_data;
            end
        end
    end

    // Independent read ports: pick a data source, then steer data and busy.
    always_comb begin
        for (int p = 0; p < NRD; p++) begin
            rd_src[p] = RD_SRC_STORE;
`ifdef RF_BYPASS_EN
            // Writes are discarded during reset, so nothing is forwarded then.
            if (!reset) begin
                if (cout_ok && (rd_addr[p] == COUT_A)) begin
                    rd_src[p] = RD_SRC_COUT;
                end else if (wr_ok && (rd_addr[p] == wr_addr)) begin
                    rd_src[p] = RD_SRC_WR;
                end
            end
`endif
            if ((R0_ZERO != 0) && (rd_addr[p] == '0)) begin
                rd_src[p] = RD_SRC_ZERO;
            end

            case (rd_src[p])
                RD_SRC_WR:    rd_data[p] = wr_data;
                RD_SRC_COUT:  rd_data[p] = cout_data;
                RD_SRC_ZERO:  rd_data[p] = '0;
                default:      rd_data[p] = mem[rd_addr[p]];
            endcase

            // Forwarded data is already final, so it is never reported busy.
            rd_busy[p] = (rd_src[p] == RD_SRC_STORE) ? busy_vec[rd_addr[p]] : 1'b0;
        end
    end

    rf_scoreboard #(
        .AW       (AW),
        .COUT_IDX (COUT_IDX),
        .R0_ZERO  (R0_ZERO)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .cout_we    (cout_we),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .busy_vec   (busy_vec),
        .alloc_err  (alloc_err)
    );

endmodule

`default_nettype wire

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter DW, default 8: register data width in bits.
REQ-002 Parameter AW, default 3: address width; the file holds 2**AW registers.
REQ-003 Parameter NRD, default 2, legal 1..4: number of independent read ports.
REQ-004 Parameter COUT_IDX, default 2**AW-1: index of the carry-out (COUT) register.
REQ-005 Parameter R0_ZERO, default 0: when 1, register 0 is hardwired to zero.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 rd_addr  in  NRD x AW  read address, one per port.
REQ-009 rd_data  out  NRD x DW  read data, one per port.
REQ-010 rd_busy  out  NRD  addressed register has an outstanding producer.
REQ-011 wr_en / wr_addr / wr_data  in  1 / AW / DW  general write port.
REQ-012 cout_we / cout_data  in  1 / DW  dedicated COUT write port.
REQ-013 alloc_en / alloc_addr  in  1 / AW  marks a register busy (producer issued).
REQ-014 busy_vec  out  2**AW  registered busy bit per register.
REQ-015 alloc_err  out  1  registered one-cycle pulse: alloc to an already-busy register.

Function
REQ-016 Reads SHALL be combinational from storage; all NRD ports are fully independent.
REQ-017 Writes SHALL take effect at the rising edge; without bypass, data is visible on rd_data the following cycle.
REQ-018 When wr_en writes COUT_IDX and cout_we is asserted in the same cycle, cout_data SHALL win.
REQ-019 When R0_ZERO=1, reads of index 0 SHALL return 0, writes to index 0 SHALL be dropped, and allocs to index 0 SHALL be ignored (no busy, no alloc_err).
REQ-020 alloc_en SHALL set busy_vec[alloc_addr] at the next edge.
REQ-021 wr_en SHALL clear busy_vec[wr_addr] at the next edge; cout_we SHALL clear busy_vec[COUT_IDX].
REQ-022 Alloc and a clearing write to the same index in one cycle SHALL leave busy set (new producer wins).
REQ-023 Alloc to an index whose busy bit is already 1 SHALL pulse alloc_err for exactly one cycle; the busy bit stays 1.
REQ-024 rd_busy[i] SHALL equal busy_vec[rd_addr[i]], subject to the bypass rules in Configuration.
REQ-025 Out-of-range COUT_IDX (>= 2**AW) SHALL be an elaboration error.

Reset
REQ-026 While reset is high, all registers SHALL load the package init values and busy_vec and alloc_err SHALL be 0; reset is asynchronous.
REQ-027 rd_data SHALL reflect the init values combinationally during reset.
REQ-028 Writes and allocs presented during reset SHALL be discarded; the first update occurs at the first edge after deassertion.

Configuration
REQ-029 With macro RF_BYPASS_EN defined, a read whose address matches an active write SHALL return the write data in the same cycle and show rd_busy=0.
REQ-030 Under RF_BYPASS_EN, cout_data SHALL take precedence in the bypass, consistent with REQ-018.
REQ-031 Under RF_BYPASS_EN, a same-cycle alloc to the same index SHALL still show rd_busy=0 for that cycle.
REQ-032 Without RF_BYPASS_EN, reads SHALL return stored contents only and rd_busy SHALL equal busy_vec exactly.

Structure
REQ-033 Package rf_pkg SHALL hold the RF_INIT constant (8-register default: index 5 = 8'h01, index 6 = 8'h07, all others 0; indices beyond 7 reset to 0) and the default DW/AW localparams.
REQ-034 Sub-module rf_scoreboard SHALL own busy_vec and alloc_err; storage and read muxing stay in reg_file_sb.

Verification
REQ-035 Reset, then read all indices -> 0 except R5=0x01, R6=0x07; busy_vec=0.
REQ-036 Write R2=0xA5 while reading R2 -> bypass build: 0xA5 same cycle; non-bypass build: old value, then 0xA5 the next cycle.
REQ-037 Same cycle: wr_en to R7=0x11 and cout_we with 0x22 -> R7=0x22 and busy_vec[7]=0.
REQ-038 alloc R3, alloc R3 again the next cycle -> alloc_err high for one cycle; then write R3=0x5A -> busy_vec[3]=0.
REQ-039 R0_ZERO=1: write R0=0xFF and alloc R0 -> R0 reads 0, busy_vec[0]=0, no alloc_err.
REQ-040 Assert reset mid-sequence with R4 busy and holding 0x3C -> immediate R4=0, busy_vec=0, alloc_err=0.
